// File: rtl/ks_seq_mult.sv
// Digit-serial carry-less (GF(2)[x]) multiplier: W x W -> 2W-1 bits, one D-bit digit of b per cycle.
// Optional multiply-accumulate seeding from the previous result is enabled by defining KSM_MAC_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | folding one partial product per cycle into the accumulator
// DONE  | result held on d with out_valid until out_ready

module ks_seq_mult #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
`ifdef KSM_MAC_EN
   input  logic           acc,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-2:0] d,
   output logic           busy
);

   localparam int N  = W / D;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * W - 1;
   localparam int PW = W + D - 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   a_r, b_r;
   logic [AW-1:0]  acc_r, acc_nxt, seed;
   logic [KW-1:0]  k;
   logic [D-1:0]   digit;
   logic [PW-1:0]  pp;
   logic           last;

   assign last = (k == KW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Schoolbook a * digit over GF(2); bit-exact with the XOR-of-AND definition.
   always_comb begin
      digit = D'(b_r >> (k * D));
      pp    = '0;
      for (int j = 0; j < D; j++) begin
         if (digit[j]) pp = pp ^ (PW'(a_r) << j);
      end
      acc_nxt = acc_r ^ (AW'(pp) << (k * D));
   end

`ifdef KSM_MAC_EN
   assign seed = acc ? d : '0;
`else
   assign seed = '0;
`endif

   // d is a separate register so it stays stable through the next operation and can seed a MAC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         acc_r <= '0;
         k     <= '0;
         d     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  k     <= '0;
                  acc_r <= seed;
               end
            end
            BUSY: begin
               acc_r <= acc_nxt;
               k     <= k + KW'(1);
               if (last) d <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule
